// File: rtl/icache_fetch_unit_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
// Holds the controller state encoding and the address/instruction geometry.
package icache_fetch_unit_pkg;

  localparam int ADDR_W = 32;
  localparam int INS_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Tag is everything above the index and the 2-bit byte offset.
  function automatic int tag_w(input int index_bits);
    return ADDR_W - 2 - index_bits;
  endfunction

endpackage

// File: rtl/icache_fetch_unit_if.sv
// Fetcher-side and memory-controller-side handshake bundle of the instruction cache.
// The slave modport is the cache's view; master is the surrounding system's view.
interface icache_fetch_unit_if;
  import icache_fetch_unit_pkg::*;

  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_ready;
  logic              ins_valid;
  logic [INS_W-1:0]  ins_out;
  logic              ic_enable;
  logic              ic_flag;
  logic [ADDR_W-1:0] ins_addr;
  logic [INS_W-1:0]  ins;
  logic              ins_rdy;

  modport slave (
    input  fetch_valid, fetch_pc, ic_enable, ins, ins_rdy,
    output fetch_ready, ins_valid, ins_out, ic_flag, ins_addr
  );

  modport master (
    output fetch_valid, fetch_pc, ic_enable, ins, ins_rdy,
    input  fetch_ready, ins_valid, ins_out, ic_flag, ins_addr
  );

endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for a direct-mapped cache with one-word lines.
// Asynchronous read port for lookup, synchronous write port for fills.
module icache_line_array
  import icache_fetch_unit_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  hit,
  output logic [INS_W-1:0]      rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [INS_W-1:0]      wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [INS_W-1:0] data_mem [LINES];

  assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

  // Only the valid bits need a reset; stale tag/data behind a clear valid bit is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache between the fetcher and the memory controller.
// Hits answer one cycle after the request; misses run a single REQ/WAIT fill.
module icache_fetch_unit
  import icache_fetch_unit_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  icache_fetch_unit_if.slave  bus
);

  localparam int TAG_W = tag_w(INDEX_BITS);

  state_e           state;
  logic             discard;
  logic             accept;
  logic             fill;
  logic             hit;
  logic [INS_W-1:0] rd_data;

  assign bus.fetch_ready = (state == ST_IDLE) && !clear;
  assign accept          = bus.fetch_valid && bus.fetch_ready;
  assign fill            = rdy && (state == ST_WAIT) && bus.ins_rdy;

  // Lookup uses the live fetch address; fill uses the latched miss address.
  icache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (bus.fetch_pc[INDEX_BITS+1:2]),
    .rd_tag  (bus.fetch_pc[ADDR_W-1:INDEX_BITS+2]),
    .hit     (hit),
    .rd_data (rd_data),
    .wr_en   (fill),
    .wr_idx  (bus.ins_addr[INDEX_BITS+1:2]),
    .wr_tag  (bus.ins_addr[ADDR_W-1:INDEX_BITS+2]),
    .wr_data (bus.ins)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      discard       <= 1'b0;
      bus.ic_flag   <= 1'b0;
      bus.ins_addr  <= '0;
      bus.ins_valid <= 1'b0;
      bus.ins_out   <= '0;
    end else if (rdy) begin
      bus.ins_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (hit) begin
              bus.ins_valid <= 1'b1;
              bus.ins_out   <= rd_data;
            end else begin
              bus.ins_addr <= bus.fetch_pc & 32'hFFFF_FFFC;
              state        <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // Nothing has left the cache yet, so a flush simply abandons the miss.
          if (clear) begin
            state <= ST_IDLE;
          end else if (bus.ic_enable) begin
            bus.ic_flag <= 1'b1;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          bus.ic_flag <= 1'b0;
          if (clear) begin
            discard <= 1'b1;
          end
          // The fill always lands; only delivery to a flushed fetcher is dropped.
          if (bus.ins_rdy) begin
            if (!discard && !clear) begin
              bus.ins_valid <= 1'b1;
              bus.ins_out   <= bus.ins;
            end
            discard <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
